// File: rtl/ucu_output_drain_pkg.sv
// Shared definitions for the UCU column output drain: FSM state encoding,
// the emitted feature type, saturation limits and FIFO depth.
// Optional build feature: DRAIN_ROUND_EN (round-half-up before the requantize
// shift); it is consumed by the requant sub-module, nothing here changes.
package ucu_output_drain_pkg;

  // Default widths of the drain datapath.
  localparam int DRAIN_ADDR_W  = 5;   // output-bank address width (32 rows)
  localparam int DRAIN_IN_W    = 16;  // pre_output width (s_feature_t)
  localparam int DRAIN_OUT_W   = 8;   // emitted signed feature width
  localparam int DRAIN_SHIFT_W = 4;   // requantize shift field width

  // Skid FIFO between the requant stage and the output stream.
  localparam int DRAIN_FIFO_DEPTH = 2;

  // Drain controller states.
  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_RUN   = 2'd1,
    DRAIN_FLUSH = 2'd2
  } drain_state_t;

  // Requantized signed feature as emitted toward writeback.
  typedef logic signed [DRAIN_OUT_W-1:0] q_feature_t;

  // Saturation limits of q_feature_t.
  localparam q_feature_t Q_MAX = q_feature_t'((1 << (DRAIN_OUT_W - 1)) - 1);
  localparam q_feature_t Q_MIN = q_feature_t'(-(1 << (DRAIN_OUT_W - 1)));

endpackage

// File: rtl/ucu_output_drain_requant.sv
// Combinational requantizer: optional ReLU, arithmetic right shift and
// saturation of one signed sample. Shared with the pooling path.
// Optional build feature: DRAIN_ROUND_EN adds round-half-up before the shift;
// without it the shift truncates toward minus infinity.
// All intermediates are IN_W+1 bits wide so the rounding bias can never wrap
// the sample before the clamp.
module ucu_output_drain_requant #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic signed [IN_W-1:0]  data_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                    relu_en_i,
  output logic signed [OUT_W-1:0] data_o
);

  localparam logic signed [IN_W:0] SAT_HI = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

  logic signed [IN_W:0] x_ext;
  logic signed [IN_W:0] bias;
  logic signed [IN_W:0] y;

  // Sign-extend the sample and clamp negatives to zero when ReLU is enabled.
  always_comb begin
    x_ext = {data_i[IN_W-1], data_i};
    if (relu_en_i && data_i[IN_W-1]) begin
      x_ext = '0;
    end
  end

`ifdef DRAIN_ROUND_EN
  // Half an LSB of the shifted result, so the shift rounds half up.
  always_comb begin
    bias = '0;
    if (shift_i != '0) begin
      bias = (IN_W + 1)'(1) << (shift_i - SHIFT_W'(1));
    end
  end
`else
  // Truncating build: no rounding bias.
  assign bias = '0;
`endif

  // Shift arithmetically, then clamp into the output range.
  always_comb begin
    y = (x_ext + bias) >>> shift_i;
    if (y > SAT_HI) begin
      data_o = SAT_HI[OUT_W-1:0];
    end else if (y < SAT_LO) begin
      data_o = SAT_LO[OUT_W-1:0];
    end else begin
      data_o = y[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ucu_output_drain.sv
// UCU column output drain. Walks the finished output bank row by row through
// the shared out_row address, captures pre_output, requantizes it and streams
// the results out. busy holds off the bank flip while a drain is in flight.
// Optional build feature: DRAIN_ROUND_EN (see ucu_output_drain_requant).
//
// Pipeline: issue (out_row registered) -> stage 1 (p1 capture) -> requant ->
// 2-entry FIFO -> output stream. Each stage advances only when the stage after
// it can take the data, so nothing is dropped under backpressure.
//
// Output handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data and out_last hold
// until that transfer; out_valid never drops without a transfer.
module ucu_output_drain
  import ucu_output_drain_pkg::*;
#(
  parameter int ADDR_W  = DRAIN_ADDR_W,
  parameter int IN_W    = DRAIN_IN_W,
  parameter int OUT_W   = DRAIN_OUT_W,
  parameter int SHIFT_W = DRAIN_SHIFT_W
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    start,
  input  logic [ADDR_W:0]         num_rows,
  input  logic [SHIFT_W-1:0]      out_shift,
  input  logic                    relu_en,
  output logic [ADDR_W-1:0]       out_row,
  input  logic signed [IN_W-1:0]  pre_output,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output drain_state_t            dbg_state_o
);

  localparam logic [1:0] FIFO_FULL = 2'(DRAIN_FIFO_DEPTH);

  // Controller and latched configuration.
  drain_state_t         state_q;
  logic [ADDR_W-1:0]    rd_q;
  logic [ADDR_W-1:0]    last_idx_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 relu_q;
  logic                 done_q;

  // Issue stage: out_row currently addresses a wanted row.
  logic [ADDR_W-1:0]    row_q;
  logic                 a0_v_q;
  logic                 a0_last_q;

  // Stage 1: captured bank sample.
  logic signed [IN_W-1:0] p1_q;
  logic                 v1_q;
  logic                 last1_q;

  // Output FIFO.
  logic signed [OUT_W-1:0] fifo_data_q [DRAIN_FIFO_DEPTH];
  logic                 fifo_last_q [DRAIN_FIFO_DEPTH];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           fifo_cnt_q;

  // Combinational control.
  logic signed [OUT_W-1:0] req_data;
  logic pop;
  logic push_ok;
  logic push;
  logic s1_load;
  logic a0_free;
  logic room;
  logic issue;
  logic issue_last;
  logic drained;

  ucu_output_drain_requant #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .data_i    (p1_q),
    .shift_i   (shift_q),
    .relu_en_i (relu_q),
    .data_o    (req_data)
  );

  // Handshake, pipeline-advance and issue decisions for this cycle.
  always_comb begin
    pop        = (fifo_cnt_q != 2'd0) && out_ready;
    push_ok    = (fifo_cnt_q != FIFO_FULL) || pop;
    push       = v1_q && push_ok;
    s1_load    = !v1_q || push_ok;
    a0_free    = !a0_v_q || s1_load;
    // Throttle: FIFO occupancy plus the stage-1 sample, net of this cycle's pop.
    room       = ({1'b0, fifo_cnt_q} + {2'b00, v1_q}) <= (3'd1 + {2'b00, pop});
    issue      = (state_q == DRAIN_RUN) && room && a0_free;
    issue_last = (rd_q == last_idx_q);
    // Everything issued has left, or the final beat transfers this cycle.
    drained    = !a0_v_q && !v1_q &&
                 ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop));
  end

  // Drain FSM: accept start, count issued rows, finish when the stream is empty.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= DRAIN_IDLE;
      rd_q       <= '0;
      last_idx_q <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DRAIN_IDLE: begin
          if (start) begin
            state_q    <= DRAIN_RUN;
            rd_q       <= '0;
            // num_rows=0 wraps to the top index, i.e. a full 32-row drain.
            last_idx_q <= ADDR_W'(num_rows - 1'b1);
            shift_q    <= out_shift;
            relu_q     <= relu_en;
          end
        end
        DRAIN_RUN: begin
          if (issue) begin
            rd_q <= rd_q + 1'b1;
            if (issue_last) begin
              state_q <= DRAIN_FLUSH;
            end
          end
        end
        DRAIN_FLUSH: begin
          if (drained) begin
            state_q <= DRAIN_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= DRAIN_IDLE;
      endcase
    end
  end

  // Read address issue and stage-1 capture of the addressed bank word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      row_q     <= '0;
      a0_v_q    <= 1'b0;
      a0_last_q <= 1'b0;
      p1_q      <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
    end else begin
      if (issue) begin
        row_q     <= rd_q;
        a0_v_q    <= 1'b1;
        a0_last_q <= issue_last;
      end else if (s1_load) begin
        a0_v_q <= 1'b0;
      end
      if (s1_load) begin
        v1_q <= a0_v_q;
        if (a0_v_q) begin
          p1_q    <= pre_output;
          last1_q <= a0_last_q;
        end
      end
    end
  end

  // Two-entry FIFO holding requantized beats; push and pop may coincide.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DRAIN_FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= req_data;
        fifo_last_q[wr_ptr_q] <= last1_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign out_row     = row_q;
  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_last    = fifo_last_q[rd_ptr_q];
  assign busy        = (state_q != DRAIN_IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
